sram_port_ctrl: RTL and testbench
=================================

# sram_port_ctrl

Front-end controller for a single-port 512×73 SRAM macro (`RW0_*` port style, one-cycle synchronous read). It sits directly upstream of the macro wrapper and drives its `RW0_addr/en/wmode/wdata` pins. It zero-fills the array after reset, arbitrates one read and one write requester with valid/ready handshakes, and returns read data with a held response register.

## Interface
Parameters:
- `ADDR_W`, default 9: address width.
- `DATA_W`, default 73: data width.
- `DEPTH`, default 512: entry count; must equal 2^ADDR_W.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock; also drives the macro's `RW0_clk`.
- `reset`  in  1  synchronous, active-high.
- `r_valid`  in  1  read request valid.
- `r_ready`  out  1  read request accepted when high with `r_valid`.
- `r_addr`  in  ADDR_W  read address.
- `resp_valid`  out  1  single-cycle pulse; read data is valid.
- `resp_data`  out  DATA_W  read data; held between responses.
- `w_valid`  in  1  write request valid.
- `w_ready`  out  1  write request accepted when high with `w_valid`.
- `w_addr`  in  ADDR_W  write address.
- `w_data`  in  DATA_W  write data.
- `init_done`  out  1  high once the array is usable.
- `sram_addr`  out  ADDR_W  to `RW0_addr`.
- `sram_en`  out  1  to `RW0_en`.
- `sram_wmode`  out  1  to `RW0_wmode`.
- `sram_wdata`  out  DATA_W  to `RW0_wdata`.
- `sram_rdata`  in  DATA_W  from `RW0_rdata`.

## Operation
- **States:** `INIT`, `IDLE`.
  - Reset enters `INIT` with `init_cnt` = 0.
  - `INIT` moves to `IDLE` when `init_cnt` = DEPTH-1 is written.
  - `IDLE` is terminal until reset.
- **INIT:** each cycle drives `sram_en`=1, `sram_wmode`=1, `sram_addr`=`init_cnt`, `sram_wdata`=0, then increments `init_cnt`.
  - `r_ready`=`w_ready`=0.
  - `init_cnt` is ADDR_W+1 bits wide, so there is no wrap before the terminal compare.
- **IDLE:** `init_done`=1.
  - Write has priority: `w_ready`=1 and `r_ready`=`!w_valid`.
  - Write handshake: `sram_en`=1, `sram_wmode`=1, `sram_addr`=`w_addr`, `sram_wdata`=`w_data`.
  - Read handshake (no write this cycle): `sram_en`=1, `sram_wmode`=0, `sram_addr`=`r_addr`.
  - No handshake: `sram_en`=0, `sram_wmode`=0. `sram_addr`/`sram_wdata` are don't-care but driven 0.
- **Simultaneous `r_valid` and `w_valid`:** the write proceeds and the read stalls. The requester holds `r_addr` until `r_ready`.
- **Read-after-write to the same address on consecutive cycles:** returns the new data, because the write has completed in the macro. No bypass logic.
- **Response:** `rd_pend` is set on a read handshake.
  - The next cycle: `resp_valid`=1 and `resp_data`=`sram_rdata`, which is captured into the hold register.
  - Otherwise `resp_data` shows the hold register.
  - Back-to-back reads give back-to-back responses.
- **Reset mid-operation:**
  - In `INIT`, the sweep restarts at address 0.
  - An in-flight read is dropped: `rd_pend` is cleared and no `resp_valid` is produced.
- **Reset values:**
  - `r_ready`=`w_ready`=0, `resp_valid`=0, `resp_data`=0, `init_done`=0.
  - `sram_en`=0, `sram_wmode`=0, `sram_addr`=0, `sram_wdata`=0.
  - During the reset cycle the macro is not enabled.

## Timing
- SRAM-side outputs are combinational from the state and handshake inputs. `sram_rdata` is valid one cycle after `sram_en`&&!`sram_wmode`.
- Cycle 0 is the first cycle with `reset`=0.
  - INIT writes addresses 0..511 in cycles 0..511.
  - `init_done`=1 and ready assertion start at cycle 512.
- Read latency: handshake at cycle N gives `resp_valid` at N+1. Throughput is 1 op/cycle.
- `init_done`, `rd_pend`, `init_cnt`, state and hold register are flops. `r_ready`/`w_ready` are combinational from state and `w_valid`.

## Configuration
- `SRAM_PORT_INIT_EN`:
  - Defined: `INIT` zero-fill as above.
  - Undefined: reset enters `IDLE` directly and `init_done`=1 from cycle 0. Array contents are undefined until written, and no INIT logic is generated.

## Structure
- Package `sram_port_pkg`: `SRAM_ADDR_W`=9, `SRAM_DATA_W`=73, `SRAM_DEPTH`=512, and the state enum `sram_port_state_e` {INIT, IDLE}.
- One natural sub-module, `sram_rdata_hold`: a `rd_pend` flop plus capture/hold mux for `resp_data`/`resp_valid`.
- The macro wrapper is instantiated by the parent, not inside this block.

## Test plan
- **Reset sweep:** release reset → `sram_en`=`sram_wmode`=1 with addresses 0..511 and data 0 in cycles 0..511; `init_done` rises at cycle 512; readies low throughout.
- **Write then read:** write addr 0x1A5 data 73'h1_2345_6789_ABCD_EF01 at cycle N, read 0x1A5 at N+1 → `resp_valid` at N+2 with that data; `resp_data` holds it while idle.
- **Contention:** `r_valid` and `w_valid` both high for 3 cycles → 3 writes, `r_ready`=0; the read is accepted on the 4th cycle and responds on the 5th.
- **Back-to-back reads:** reads of addrs 5, 6, 7 on consecutive cycles → responses on consecutive cycles, in order, each reading 0 after init.
- **Mid-operation reset:** reset at sweep cycle 200 → on release the sweep restarts at addr 0. Reset the cycle after a read handshake → no `resp_valid`, and `resp_data`=0.
- **Macro undefined:** with `SRAM_PORT_INIT_EN` not defined → `init_done`=1 and `w_ready`=1 at cycle 0; a write at cycle 0 reaches `sram_*`.

Source files
------------

// File: rtl/sram_port_pkg.sv
// sram_port_pkg
// Shared constants and the controller state type for sram_port_ctrl.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_DEPTH : geometry of the 512x73 macro
//   sram_port_state_e                     : controller state (INIT sweep, IDLE)
package sram_port_pkg;

  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 73;
  localparam int SRAM_DEPTH  = 512;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } sram_port_state_e;

endpackage

// File: rtl/sram_rdata_hold.sv
// sram_rdata_hold
// Read-response stage for sram_port_ctrl. Remembers that a read was issued
// (rd_pend) and, one cycle later, forwards the macro's read data while
// capturing it into a hold register so resp_data stays stable between reads.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   rd_fire       : read handshake happened this cycle
//   sram_rdata    : macro read data, valid the cycle after rd_fire
//   resp_valid    : one-cycle pulse, response data valid
//   resp_data     : live read data on resp_valid, held value otherwise
module sram_rdata_hold #(
  parameter int DATA_W = 73
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);

  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  always_comb begin
    rd_pend_d = rd_fire;
    hold_d    = hold_q;
    if (rd_pend_q) begin
      hold_d = sram_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      hold_q    <= hold_d;
    end
  end

  // Outputs are masked while reset is asserted so an in-flight read that
  // meets a reset never produces a response, and the data reads as zero.
  always_comb begin
    resp_valid = 1'b0;
    resp_data  = '0;
    if (!reset) begin
      resp_valid = rd_pend_q;
      resp_data  = rd_pend_q ? sram_rdata : hold_q;
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
// Front end for a single-port 512x73 SRAM macro (RW0_* pins, one-cycle
// synchronous read). Optionally zero-fills the array after reset, arbitrates
// one write and one read requester (write wins), and returns read data
// through a held response register.
//
// Handshakes: a request transfers on a cycle where its valid and ready are
// both high. Ready depends only on state and w_valid, never on r_valid or
// the address/data, and a requester must hold its payload until accepted.
//
// Build option: SRAM_PORT_INIT_EN
//   defined   : after reset the controller sweeps every address writing 0,
//               then enters IDLE and raises init_done.
//   undefined : reset enters IDLE directly; init_done is high from the first
//               cycle out of reset and no sweep logic exists.
//
// Ports:
//   clock, reset                : sole clock, synchronous active-high reset
//   r_valid/r_ready/r_addr      : read request channel
//   resp_valid/resp_data        : read response (pulse / held data)
//   w_valid/w_ready/w_addr/w_data : write request channel
//   init_done                   : array usable
//   sram_addr/en/wmode/wdata    : to RW0_addr/en/wmode/wdata
//   sram_rdata                  : from RW0_rdata
//
// The FSM state is held in state_q (type sram_port_state_e) for checkers.
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("sram_port_ctrl: DEPTH must equal 2**ADDR_W");
  end

  sram_port_state_e state_q, state_d;
  logic             init_done_q, init_done_d;
  logic             in_idle;
  logic             w_fire, r_fire;

`ifdef SRAM_PORT_INIT_EN
  localparam int CNT_W = ADDR_W + 1;

  // One extra bit so the counter cannot wrap before the terminal compare.
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == CNT_W'(DEPTH - 1)) begin
        state_d     = IDLE;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end
`else
  // No sweep: IDLE is entered straight from reset and never left.
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      init_done_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
    end
  end
`endif

  // Everything facing the requesters and the macro is masked during the reset
  // cycle, so the macro is never enabled while reset is high.
  assign in_idle   = (state_q == IDLE) && !reset;
  assign init_done = init_done_q && !reset;
  assign w_ready   = in_idle;
  assign r_ready   = in_idle && !w_valid;
  assign w_fire    = w_valid && w_ready;
  assign r_fire    = r_valid && r_ready;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
`ifdef SRAM_PORT_INIT_EN
    if (!reset && state_q == INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt_q[ADDR_W-1:0];
    end else
`endif
    if (w_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_addr;
      sram_wdata = w_data;
    end else if (r_fire) begin
      sram_en    = 1'b1;
      sram_addr  = r_addr;
    end
  end

  sram_rdata_hold #(
    .DATA_W (DATA_W)
  ) u_rdata_hold (
    .clock      (clock),
    .reset      (reset),
    .rd_fire    (r_fire),
    .sram_rdata (sram_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl
// Directed bench for sram_port_ctrl with a behavioural model of the
// single-port macro (one-cycle synchronous read). Inputs change 1 time unit
// after the rising edge; outputs are checked on the falling edge.
module tb_sram_port_ctrl;

  localparam int AW = 9;
  localparam int DW = 73;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [AW-1:0] r_addr = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- macro model ----------------
  logic [DW-1:0] mem [0:511];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  sram_port_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset   = 1'b1;
    w_valid = 1'b1; w_addr = 9'h033; w_data = '1;
    r_valid = 1'b1; r_addr = 9'h044;
    at_sample();
    n_tests++;
    if ({r_ready, w_ready, resp_valid, init_done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {r_ready, w_ready, resp_valid, init_done});
    end
    n_tests++;
    if ({sram_en, sram_wmode} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sram_ctl: got %b want 00", {sram_en, sram_wmode});
    end
    n_tests++;
    if (sram_addr !== '0 || sram_wdata !== '0) begin
      n_fail++; $display("FAIL reset_sram_bus: addr %h wdata %h want 0/0", sram_addr, sram_wdata);
    end
    n_tests++;
    if (resp_data !== '0) begin
      n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data);
    end
    next_cycle();
  endtask

`ifdef SRAM_PORT_INIT_EN
  task automatic check_sweep(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      at_sample();
      n_tests++;
      if ({sram_en, sram_wmode, r_ready, w_ready, init_done} !== 5'b11000 ||
          sram_addr !== AW'(i) || sram_wdata !== '0) begin
        n_fail++;
        $display("FAIL %s_cycle%0d: ctl %b addr %h wdata %h want 11000 %h 0", tag, i,
                 {sram_en, sram_wmode, r_ready, w_ready, init_done}, sram_addr, sram_wdata, AW'(i));
      end
      next_cycle();
    end
  endtask

  task automatic test_init_sweep();
    reset   = 1'b0;
    w_valid = 1'b1; w_data = '1;
    r_valid = 1'b1;
    check_sweep(200, "sweep_a");
    reset = 1'b1;
    at_sample();
    n_tests++;
    if (sram_en !== 1'b0) begin
      n_fail++; $display("FAIL sweep_reset_en: got %b want 0", sram_en);
    end
    next_cycle();
    reset = 1'b0;
    check_sweep(512, "sweep_b");
    at_sample();
    n_tests++;
    if ({init_done, w_ready, r_ready} !== 3'b110) begin
      n_fail++; $display("FAIL sweep_done: got %b want 110", {init_done, w_ready, r_ready});
    end
    w_valid = 1'b0; r_valid = 1'b0;
    next_cycle();
  endtask
`else
  task automatic test_cycle0();
    reset   = 1'b0;
    w_valid = 1'b1; w_addr = 9'h010; w_data = 73'h0ABC;
    r_valid = 1'b1; r_addr = 9'h010;
    at_sample();
    n_tests++;
    if ({init_done, w_ready, r_ready, sram_en, sram_wmode} !== 5'b11011) begin
      n_fail++; $display("FAIL cycle0_ctl: got %b want 11011", {init_done, w_ready, r_ready, sram_en, sram_wmode});
    end
    n_tests++;
    if (sram_addr !== 9'h010 || sram_wdata !== 73'h0ABC) begin
      n_fail++; $display("FAIL cycle0_bus: addr %h wdata %h want 010 0abc", sram_addr, sram_wdata);
    end
    next_cycle();
    w_valid = 1'b0;
    at_sample();
    n_tests++;
    if ({r_ready, sram_en, sram_wmode} !== 3'b110 || sram_addr !== 9'h010) begin
      n_fail++; $display("FAIL cycle1_read: ctl %b addr %h want 110 010", {r_ready, sram_en, sram_wmode}, sram_addr);
    end
    next_cycle();
    r_valid = 1'b0;
    at_sample();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_data !== 73'h0ABC) begin
      n_fail++; $display("FAIL cycle2_resp: valid %b data %h want 1 0abc", resp_valid, resp_data);
    end
    next_cycle();
  endtask
`endif

  task automatic test_write_read();
    logic [DW-1:0] d;
    d = 73'h1_2345_6789_ABCD_EF01;
    w_valid = 1'b1; w_addr = 9'h1A5; w_data = d;
    at_sample();
    n_tests++;
    if ({w_ready, sram_en, sram_wmode} !== 3'b111 || sram_addr !== 9'h1A5 || sram_wdata !== d) begin
      n_fail++; $display("FAIL wr_issue: ctl %b addr %h wdata %h", {w_ready, sram_en, sram_wmode}, sram_addr, sram_wdata);
    end
    next_cycle();
    w_valid = 1'b0; w_data = 73'h1F;
    r_valid = 1'b1; r_addr = 9'h1A5;
    at_sample();
    n_tests++;
    if ({r_ready, sram_en, sram_wmode, resp_valid} !== 4'b1100 || sram_addr !== 9'h1A5) begin
      n_fail++; $display("FAIL rd_issue: ctl %b addr %h want 1100 1a5", {r_ready, sram_en, sram_wmode, resp_valid}, sram_addr);
    end
    next_cycle();
    r_valid = 1'b0;
    at_sample();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_data !== d) begin
      n_fail++; $display("FAIL raw_resp: valid %b data %h want 1 %h", resp_valid, resp_data, d);
    end
    n_tests++;
    if (sram_en !== 1'b0 || sram_addr !== '0 || sram_wdata !== '0) begin
      n_fail++; $display("FAIL idle_bus: en %b addr %h wdata %h want 0 0 0", sram_en, sram_addr, sram_wdata);
    end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      at_sample();
      n_tests++;
      if (resp_valid !== 1'b0 || resp_data !== d) begin
        n_fail++; $display("FAIL resp_hold%0d: valid %b data %h want 0 %h", i, resp_valid, resp_data, d);
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    logic [DW-1:0] wd [3];
    logic [AW-1:0] wa [3];
    wd[0] = 73'h111; wd[1] = 73'h222; wd[2] = 73'h1_0000_0000_0000_0333;
    wa[0] = 9'h0F0;  wa[1] = 9'h0F1;  wa[2] = 9'h0F0;
    r_valid = 1'b1; r_addr = 9'h0F0;
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1; w_addr = wa[i]; w_data = wd[i];
      at_sample();
      n_tests++;
      if ({r_ready, w_ready, sram_en, sram_wmode} !== 4'b0111 || sram_addr !== wa[i] || sram_wdata !== wd[i]) begin
        n_fail++; $display("FAIL contend_wr%0d: ctl %b addr %h wdata %h", i, {r_ready, w_ready, sram_en, sram_wmode}, sram_addr, sram_wdata);
      end
      next_cycle();
    end
    w_valid = 1'b0;
    at_sample();
    n_tests++;
    if ({r_ready, sram_en, sram_wmode} !== 3'b110 || sram_addr !== 9'h0F0) begin
      n_fail++; $display("FAIL contend_rd: ctl %b addr %h want 110 0f0", {r_ready, sram_en, sram_wmode}, sram_addr);
    end
    next_cycle();
    r_valid = 1'b0;
    at_sample();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_data !== wd[2]) begin
      n_fail++; $display("FAIL contend_resp: valid %b data %h want 1 %h", resp_valid, resp_data, wd[2]);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
`ifdef SRAM_PORT_INIT_EN
    vals[0] = '0; vals[1] = '0; vals[2] = '0;
`else
    vals[0] = 73'h5A5; vals[1] = 73'h0_FFFF_0000_1234_5678; vals[2] = 73'h1_8000_0000_0000_0007;
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1; w_addr = AW'(5 + i); w_data = vals[i];
      next_cycle();
    end
    w_valid = 1'b0;
`endif
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      r_valid = (i < 3);
      r_addr  = AW'(5 + i);
      at_sample();
      if (i < 3) begin
        n_tests++;
        if (r_ready !== 1'b1 || sram_addr !== AW'(5 + i)) begin
          n_fail++; $display("FAIL b2b_issue%0d: ready %b addr %h", i, r_ready, sram_addr);
        end
      end
      if (i > 0) begin
        n_tests++;
        if (resp_valid !== 1'b1 || exp_q.size() == 0 || resp_data !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_resp%0d: valid %b data %h", i - 1, resp_valid, resp_data);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (i < 3) exp_q.push_back(vals[i]);
      next_cycle();
    end
    r_valid = 1'b0;
    at_sample();
    n_tests++;
    if (resp_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_tail: valid %b left %0d want 0 0", resp_valid, exp_q.size());
    end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    r_valid = 1'b1; r_addr = 9'h1A5;
    at_sample();
    n_tests++;
    if (r_ready !== 1'b1) begin
      n_fail++; $display("FAIL mrst_issue: ready %b want 1", r_ready);
    end
    next_cycle();
    r_valid = 1'b0;
    reset   = 1'b1;
    at_sample();
    n_tests++;
    if (resp_valid !== 1'b0 || resp_data !== '0 || sram_en !== 1'b0) begin
      n_fail++; $display("FAIL mrst_during: valid %b data %h en %b want 0 0 0", resp_valid, resp_data, sram_en);
    end
    next_cycle();
    reset = 1'b0;
    at_sample();
    n_tests++;
    if (resp_valid !== 1'b0 || resp_data !== '0) begin
      n_fail++; $display("FAIL mrst_after: valid %b data %h want 0 0", resp_valid, resp_data);
    end
`ifdef SRAM_PORT_INIT_EN
    n_tests++;
    if (init_done !== 1'b0 || sram_addr !== '0 || sram_wmode !== 1'b1) begin
      n_fail++; $display("FAIL mrst_sweep: done %b addr %h wmode %b want 0 0 1", init_done, sram_addr, sram_wmode);
    end
`else
    n_tests++;
    if (init_done !== 1'b1 || w_ready !== 1'b1) begin
      n_fail++; $display("FAIL mrst_idle: done %b w_ready %b want 1 1", init_done, w_ready);
    end
`endif
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (2) @(posedge clock);
    #1;
    test_reset();
`ifdef SRAM_PORT_INIT_EN
    test_init_sweep();
`else
    test_cycle0();
`endif
    test_write_read();
    test_contention();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
